// File: rtl/sm_operand_entry.sv
// sm_operand_entry
//   Operand-entry stage for the sign-magnitude adder test. It synchronizes and
//   debounces three pushbuttons, synchronizes the select switch, and holds two
//   sign-magnitude operands that the buttons increment, decrement or negate.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   btn_inc  in   async pushbutton, increments the selected operand
//   btn_dec  in   async pushbutton, decrements the selected operand
//   btn_neg  in   async pushbutton, negates the selected operand
//   sel      in   async switch, 0 selects a, 1 selects b
//   a, b     out  N-bit sign-magnitude operands (bit N-1 = sign), registered
//   upd      out  one-cycle pulse in the first cycle a new a/b value is visible
module sm_operand_entry #(
  parameter int N        = 4,
  parameter int DB_TICKS = 2000000,
  parameter int INIT     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_inc,
  input  logic         btn_dec,
  input  logic         btn_neg,
  input  logic         sel,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         upd
);

  localparam int           CW     = $clog2(DB_TICKS);
  localparam logic [CW-1:0] LAST  = CW'(DB_TICKS - 1);
  localparam logic [N-2:0] MAX_M  = {(N-1){1'b1}};
  localparam logic [N-2:0] ONE_M  = (N-1)'(1'b1);
  localparam logic [N-1:0] INIT_V = {1'b0, (N-1)'(INIT)};

  typedef enum logic [1:0] {
    IDLE0 = 2'b00,
    WAIT1 = 2'b01,
    IDLE1 = 2'b10,
    WAIT0 = 2'b11
  } db_state_e;

  // Bit order in the synchronizer vectors: 0 inc, 1 dec, 2 neg, 3 sel.
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  db_state_e     st_q  [3];
  db_state_e     st_d  [3];
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    press_q, press_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          upd_q, upd_d;
  logic [N-1:0]  tgt_s;
  logic [N-1:0]  nv_s;

  // Increment; a negative value moves toward zero, -1 becomes +0.
  function automatic logic [N-1:0] f_inc(input logic [N-1:0] v);
    logic [N-2:0] m;
    m = v[N-2:0];
    if (!v[N-1]) begin
      if (m != MAX_M) f_inc = {1'b0, m + ONE_M};
      else            f_inc = v;
    end else begin
      if (m > ONE_M)  f_inc = {1'b1, m - ONE_M};
      else            f_inc = '0;
    end
  endfunction

  // Decrement; +0 steps to -1 so negative zero never appears.
  function automatic logic [N-1:0] f_dec(input logic [N-1:0] v);
    logic [N-2:0] m;
    m = v[N-2:0];
    if (!v[N-1]) begin
      if (m != '0)    f_dec = {1'b0, m - ONE_M};
      else            f_dec = {1'b1, ONE_M};
    end else begin
      if (m != MAX_M) f_dec = {1'b1, m + ONE_M};
      else            f_dec = v;
    end
  endfunction

  // Negate; zero is always returned as +0.
  function automatic logic [N-1:0] f_neg(input logic [N-1:0] v);
    if (v[N-2:0] != '0) f_neg = {~v[N-1], v[N-2:0]};
    else                f_neg = '0;
  endfunction

  // Two-flop synchronizer next-state.
  always_comb begin
    sync1_d = {sel, btn_neg, btn_dec, btn_inc};
    sync2_d = sync1_q;
  end

  // Debounce FSMs, one per button; press fires once on an accepted rise.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      st_d[i]    = st_q[i];
      cnt_d[i]   = cnt_q[i];
      press_d[i] = 1'b0;
      case (st_q[i])
        IDLE0: begin
          if (sync2_q[i]) begin
            st_d[i]  = WAIT1;
            cnt_d[i] = '0;
          end else begin
            st_d[i]  = IDLE0;
          end
        end
        WAIT1: begin
          if (!sync2_q[i]) begin
            st_d[i]    = IDLE0;
          end else if (cnt_q[i] == LAST) begin
            st_d[i]    = IDLE1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CW'(1'b1);
          end
        end
        IDLE1: begin
          if (!sync2_q[i]) begin
            st_d[i]  = WAIT0;
            cnt_d[i] = '0;
          end else begin
            st_d[i]  = IDLE1;
          end
        end
        WAIT0: begin
          if (sync2_q[i]) begin
            st_d[i]  = IDLE1;
          end else if (cnt_q[i] == LAST) begin
            st_d[i]  = IDLE0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1'b1);
          end
        end
        default: begin
          st_d[i]  = IDLE0;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Operand update: neg beats inc beats dec; losers are dropped.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    upd_d = 1'b0;
    tgt_s = sync2_q[3] ? b_q : a_q;
    if (press_q[2])      nv_s = f_neg(tgt_s);
    else if (press_q[0]) nv_s = f_inc(tgt_s);
    else                 nv_s = f_dec(tgt_s);
    if (press_q != 3'b000) begin
      upd_d = 1'b1;
      if (sync2_q[3]) b_d = nv_s;
      else            a_d = nv_s;
    end else begin
      upd_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= IDLE0;
        cnt_q[i] <= '0;
      end
      press_q <= 3'b000;
      a_q     <= INIT_V;
      b_q     <= INIT_V;
      upd_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      press_q <= press_d;
      a_q     <= a_d;
      b_q     <= b_d;
      upd_q   <= upd_d;
    end
  end

  assign a   = a_q;
  assign b   = b_q;
  assign upd = upd_q;

endmodule

// File: tb/tb_sm_operand_entry.sv
// tb_sm_operand_entry
//   Directed bench for sm_operand_entry with N=4, DB_TICKS=4, INIT=2.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_sm_operand_entry;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         btn_inc, btn_dec, btn_neg, sel;
  logic [N-1:0] a, b;
  logic         upd;
  int           errors = 0;
  int           checks = 0;

  sm_operand_entry #(.N(4), .DB_TICKS(4), .INIT(2)) dut (
    .clk(clk), .reset(reset), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .btn_neg(btn_neg), .sel(sel), .a(a), .b(b), .upd(upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n edges, report number of upd pulses and the first edge (1-based) with upd.
  task automatic watch(input int n, output int cnt, output int first);
    cnt = 0;
    first = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (upd) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
  endtask

  // mask = {neg, dec, inc}; hold 12 edges, release 10 edges.
  task automatic press(input string tag, input logic [2:0] mask, input logic [N-1:0] exp_v);
    int c, f, c2, f2;
    {btn_neg, btn_dec, btn_inc} = mask;
    watch(12, c, f);
    {btn_neg, btn_dec, btn_inc} = 3'b000;
    watch(10, c2, f2);
    check({tag, " upd_count"}, c, 1);
    check({tag, " latency"}, f, 8);
    check({tag, " release"}, c2, 0);
    check({tag, " value"}, sel ? b : a, exp_v);
  endtask

  initial begin
    int c, f;
    reset = 1'b1;
    {btn_inc, btn_dec, btn_neg, sel} = 4'b0000;
    tick();
    tick();
    check("rst_a", a, 4'b0010);
    check("rst_b", b, 4'b0010);
    check("rst_upd", upd, 1'b0);
    reset = 1'b0;
    watch(20, c, f);
    check("idle_upd", c, 0);
    check("idle_a", a, 4'b0010);
    check("idle_b", b, 4'b0010);

    // Exact latency of one held inc press on a.
    btn_inc = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("inc_upd_e%0d", i), upd, (i == 8) ? 1'b1 : 1'b0);
      check($sformatf("inc_a_e%0d", i), a, (i >= 8) ? 4'b0011 : 4'b0010);
    end
    btn_inc = 1'b0;
    watch(10, c, f);
    check("inc_release_upd", c, 0);
    check("inc_a_final", a, 4'b0011);
    check("inc_b_untouched", b, 4'b0010);

    // Glitch: high 3, low 1, then high 10; timing counts from the second rise.
    btn_inc = 1'b1;
    tick(); tick(); tick();
    btn_inc = 1'b0;
    tick();
    btn_inc = 1'b1;
    watch(10, c, f);
    btn_inc = 1'b0;
    check("glitch_upd_count", c, 1);
    check("glitch_latency", f, 8);
    watch(10, c, f);
    check("glitch_release", c, 0);
    check("glitch_a", a, 4'b0100);

    // Operand b walk through zero.
    sel = 1'b1;
    tick(); tick(); tick();
    press("b_dec1", 3'b010, 4'b0001);
    press("b_dec2", 3'b010, 4'b0000);
    press("b_dec_zero", 3'b010, 4'b1001);
    press("b_neg_m1", 3'b100, 4'b0001);
    press("b_dec3", 3'b010, 4'b0000);
    press("b_dec4", 3'b010, 4'b1001);
    press("b_inc_m1", 3'b001, 4'b0000);
    press("b_neg_zero", 3'b100, 4'b0000);
    check("b_walk_a_untouched", a, 4'b0100);

    // Saturation on a.
    sel = 1'b0;
    tick(); tick(); tick();
    press("a_inc5", 3'b001, 4'b0101);
    press("a_inc6", 3'b001, 4'b0110);
    press("a_inc7", 3'b001, 4'b0111);
    press("a_inc_sat", 3'b001, 4'b0111);
    press("a_neg7", 3'b100, 4'b1111);
    press("a_dec_sat", 3'b010, 4'b1111);
    check("sat_b_untouched", b, 4'b0000);

    // Simultaneous neg and inc on a = +3.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_a", a, 4'b0010);
    press("a_inc3", 3'b001, 4'b0011);
    press("neg_beats_inc", 3'b101, 4'b1011);

    // Reset at debounce count 2 with the button still held.
    btn_inc = 1'b1;
    watch(5, c, f);
    check("midrst_no_upd", c, 0);
    reset = 1'b1;
    tick();
    check("midrst_a", a, 4'b0010);
    check("midrst_b", b, 4'b0010);
    check("midrst_upd", upd, 1'b0);
    reset = 1'b0;
    watch(12, c, f);
    btn_inc = 1'b0;
    check("midrst_upd_count", c, 1);
    check("midrst_latency", f, 8);
    check("midrst_a_after", a, 4'b0011);
    check("midrst_b_after", b, 4'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
